// File: rtl/chan_550_simple_snap_ctrl.sv
// One-shot snapshot controller: decodes the startBuffer register word and streams
// N valid channeliser samples into a BRAM write port, exposing progress/done status.
module chan_550_simple_snap_ctrl #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  user_clk,
   input  logic                  user_rst,
   input  logic [31:0]           start_reg,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   input  logic                  ext_trig,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0] bram_data,
   output logic                  bram_we,
   output logic [ADDR_WIDTH:0]   status_count,
   output logic                  status_busy,
   output logic                  status_done
);

   localparam int unsigned Depth = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

   state_e              state_q, state_d;
   logic                start_d;
   logic                start_rise;
   logic [ADDR_WIDTH:0] len_q, len_d;
   logic [ADDR_WIDTH:0] len_n;
   logic                take;
   logic                clear_count;
   logic [15:0]         len_field;
   logic                unused_start_bits;

   assign start_rise        = start_reg[0] & ~start_d;
   assign len_field         = start_reg[31:16];
   assign unused_start_bits = ^start_reg[15:2];

   // A zero length field means "fill the whole buffer"; oversize requests clamp to depth.
   always_comb begin
      if (len_field == 16'd0 || 32'(len_field) >= Depth) begin
         len_n = (ADDR_WIDTH + 1)'(Depth);
      end else begin
         len_n = (ADDR_WIDTH + 1)'(32'(len_field));
      end
   end

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      take        = 1'b0;
      clear_count = 1'b0;
      case (state_q)
         StIdle, StDone: begin
            if (start_rise) begin
               len_d       = len_n;
               clear_count = 1'b1;
               state_d     = start_reg[1] ? StArmed : StCapture;
            end
         end
         StArmed: begin
            if (!start_reg[0]) begin
               state_d = StIdle;
            end else if (ext_trig) begin
               state_d = StCapture;
               take    = in_valid;
            end
         end
         StCapture: take = in_valid;
         default:   state_d = StIdle;
      endcase
      // Final sample: DONE coincides with the registered write of index N-1.
      if (take && (status_count + 1'b1) == len_q) begin
         state_d = StDone;
      end
   end

   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         state_q      <= StIdle;
         start_d      <= 1'b0;
         len_q        <= '0;
         bram_we      <= 1'b0;
         bram_addr    <= '0;
         bram_data    <= '0;
         status_count <= '0;
      end else begin
         state_q <= state_d;
         start_d <= start_reg[0];
         len_q   <= len_d;
         bram_we <= take;
         if (take) begin
            bram_addr    <= status_count[ADDR_WIDTH-1:0];
            bram_data    <= in_data;
            status_count <= status_count + 1'b1;
         end else if (clear_count) begin
            status_count <= '0;
         end
      end
   end

   assign status_busy = (state_q == StArmed) || (state_q == StCapture);
   assign status_done = (state_q == StDone);

endmodule

// File: tb/tb_chan_550_simple_snap_ctrl.sv
// Bench for chan_550_simple_snap_ctrl: directed scenarios plus random stimulus, checked
// every cycle against a transaction-level model of the capture rules.
module tb_chan_550_simple_snap_ctrl;

   logic        user_clk = 1'b0;
   logic        user_rst = 1'b1;
   logic [31:0] start_reg = '0;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        ext_trig = 1'b0;
   logic [9:0]  bram_addr;
   logic [31:0] bram_data;
   logic        bram_we;
   logic [10:0] status_count;
   logic        status_busy;
   logic        status_done;

   chan_550_simple_snap_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
      .user_clk     (user_clk),
      .user_rst     (user_rst),
      .start_reg    (start_reg),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .ext_trig     (ext_trig),
      .bram_addr    (bram_addr),
      .bram_data    (bram_data),
      .bram_we      (bram_we),
      .status_count (status_count),
      .status_busy  (status_busy),
      .status_done  (status_done)
   );

   always #5 user_clk = ~user_clk;

   int total = 0;
   int bad = 0;

   // Model: mode 0 idle, 1 waiting for trigger, 2 capturing, 3 finished.
   int          m_mode = 0;
   int          m_n = 0;
   int          m_cnt = 0;
   bit          m_prev = 1'b0;
   bit          e_we = 1'b0;
   int          e_addr = 0;
   logic [31:0] e_data = '0;

   int          wq_addr[$];
   logic [31:0] wq_data[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_write();
      e_we   = 1'b1;
      e_addr = m_cnt;
      e_data = in_data;
      m_cnt++;
      if (m_cnt == m_n) m_mode = 3;
   endtask

   task automatic model_step();
      bit rise;
      int len;
      e_we = 1'b0;
      if (user_rst) begin
         m_mode = 0; m_cnt = 0; m_prev = 1'b0; e_addr = 0; e_data = '0;
         return;
      end
      rise   = start_reg[0] && !m_prev;
      m_prev = start_reg[0];
      len    = int'(start_reg[31:16]);
      case (m_mode)
         0, 3: if (rise) begin
            m_n    = (len == 0 || len > 1024) ? 1024 : len;
            m_cnt  = 0;
            m_mode = start_reg[1] ? 1 : 2;
         end
         1: if (!start_reg[0]) m_mode = 0;
            else if (ext_trig) begin
               m_mode = 2;
               if (in_valid) model_write();
            end
         2: if (in_valid) model_write();
         default: m_mode = 0;
      endcase
   endtask

   // One clock: advance the model on the inputs about to be sampled, then compare after the edge.
   task automatic tick();
      model_step();
      @(posedge user_clk);
      #1;
      chk("we", bram_we, e_we);
      if (e_we) begin
         chk("addr", bram_addr, e_addr);
         chk("data", bram_data, e_data);
      end
      chk("count", status_count, m_cnt);
      chk("busy", status_busy, (m_mode == 1 || m_mode == 2));
      chk("done", status_done, (m_mode == 3));
      if (bram_we) begin
         wq_addr.push_back(int'(bram_addr));
         wq_data.push_back(bram_data);
      end
   endtask

   task automatic clear_log();
      wq_addr.delete();
      wq_data.delete();
   endtask

   initial begin
      // Reset with activity on the inputs.
      user_rst = 1'b1; in_valid = 1'b1; start_reg = '0;
      for (int i = 0; i < 4; i++) begin
         in_data = $urandom;
         tick();
      end
      chk("rst we", bram_we, 0);
      chk("rst addr", bram_addr, 0);
      chk("rst data", bram_data, 0);
      chk("rst count", status_count, 0);
      chk("rst busy", status_busy, 0);
      chk("rst done", status_done, 0);
      user_rst = 1'b0; in_valid = 1'b0;
      tick();

      // Untriggered short capture of 4.
      clear_log();
      start_reg = 32'h0004_0001; in_valid = 1'b1; in_data = 32'h0FF;
      tick();
      for (int k = 0; k < 8; k++) begin
         in_data = 32'h100 + k;
         tick();
      end
      chk("short writes", wq_addr.size(), 4);
      if (wq_addr.size() == 4) begin
         chk("short first data", wq_data[0], 32'h100);
         chk("short last addr", wq_addr[3], 3);
         chk("short last data", wq_data[3], 32'h103);
      end
      chk("short count", status_count, 4);
      chk("short done", status_done, 1);

      // Full depth with in_valid toggling.
      start_reg = '0; in_valid = 1'b0;
      tick();
      clear_log();
      start_reg = 32'h0000_0001;
      for (int i = 0; i < 2100; i++) begin
         in_valid = (i % 2 == 0);
         in_data  = $urandom;
         tick();
      end
      chk("full writes", wq_addr.size(), 1024);
      begin
         bit ordered = 1'b1;
         foreach (wq_addr[j]) if (wq_addr[j] != j) ordered = 1'b0;
         chk("full in order", ordered, 1);
      end
      chk("full count", status_count, 1024);
      chk("full done", status_done, 1);

      // Triggered capture of 2.
      start_reg = '0; in_valid = 1'b0;
      tick();
      clear_log();
      start_reg = 32'h0002_0003;
      for (int i = 0; i < 19; i++) begin
         in_valid = $urandom_range(0, 1);
         in_data  = $urandom;
         tick();
      end
      chk("trig no early writes", wq_addr.size(), 0);
      chk("trig armed busy", status_busy, 1);
      ext_trig = 1'b1; in_valid = 1'b1; in_data = 32'hAA;
      tick();
      ext_trig = 1'b0; in_data = 32'hBB;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("trig writes", wq_addr.size(), 2);
      if (wq_addr.size() == 2) begin
         chk("trig d0", wq_data[0], 32'hAA);
         chk("trig a0", wq_addr[0], 0);
         chk("trig d1", wq_data[1], 32'hBB);
         chk("trig a1", wq_addr[1], 1);
      end
      chk("trig done", status_done, 1);

      // Abort while armed.
      start_reg = '0;
      tick();
      clear_log();
      start_reg = 32'h0004_0003; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      start_reg = '0;
      tick();
      tick();
      chk("abort writes", wq_addr.size(), 0);
      chk("abort busy", status_busy, 0);

      // Restart edge mid-capture is ignored.
      clear_log();
      in_valid = 1'b0; start_reg = 32'h0008_0001;
      tick();
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      in_valid = 1'b0; start_reg = '0;
      tick();
      start_reg = 32'h0008_0001;
      tick();
      chk("restart ignored count", status_count, 3);
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      chk("restart writes", wq_addr.size(), 8);
      chk("restart count", status_count, 8);

      // Reset mid-capture, then a fresh capture.
      start_reg = '0; in_valid = 1'b0;
      tick();
      start_reg = 32'h0008_0001;
      tick();
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      user_rst = 1'b1;
      tick();
      chk("midrst we", bram_we, 0);
      chk("midrst count", status_count, 0);
      user_rst = 1'b0; start_reg = '0; in_valid = 1'b0;
      tick();
      clear_log();
      start_reg = 32'h0008_0001;
      tick();
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      chk("fresh writes", wq_addr.size(), 8);
      if (wq_addr.size() > 0) chk("fresh first addr", wq_addr[0], 0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         user_rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 39) == 0) begin
            if (start_reg[0]) start_reg[0] = 1'b0;
            else begin
               start_reg[31:16] = ($urandom_range(0, 19) == 0) ? 16'd1030
                                                               : 16'($urandom_range(1, 12));
               start_reg[15:2]  = 14'($urandom);
               start_reg[1]     = $urandom_range(0, 1);
               start_reg[0]     = 1'b1;
            end
         end
         in_valid = ($urandom_range(0, 3) != 0);
         ext_trig = ($urandom_range(0, 7) == 0);
         in_data  = $urandom;
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
